seq_detector_param: RTL

- Parametrised Mealy/Moore sequence detector; the next generation of the two-input a-then-b detector used in the lab FSM set.
- Matches a runtime-programmable pattern of DEPTH symbols, each SYM_W bits wide, on a qualified input stream.
- Optional hold-in-match mode; saturating match counter.
- Sits between input synchronisers and the display/LED logic of the lab top level.

---
 rtl/seq_detector_param.sv | 95 +++++++++
 1 files changed

// File: rtl/seq_detector_param.sv
// Programmable DEPTH-symbol sequence detector with a Moore detect, a Mealy hit,
// optional hold on a repeating final symbol, and a saturating match counter.
module seq_detector_param #(
    parameter int unsigned SYM_W = 2,
    parameter int unsigned DEPTH = 3,
    parameter int unsigned HOLD  = 1,
    parameter int unsigned CNT_W = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clear,
    input  logic                           in_valid,
    input  logic [SYM_W-1:0]               sym,
    input  logic [DEPTH*SYM_W-1:0]         pattern,
    output logic [$clog2(DEPTH+1)-1:0]     progress,
    output logic                           detect,
    output logic                           hit,
    output logic [CNT_W-1:0]               match_cnt
);

    localparam int unsigned KW = $clog2(DEPTH + 1);
    localparam logic [KW-1:0] KFull = KW'(DEPTH);

    logic [KW-1:0]    k_q, k_d, k_adv;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SYM_W-1:0] cur_sym, first_sym, last_sym;
    logic             hold_case;
    int unsigned      k_int;

    assign k_int     = 32'(k_q);
    assign first_sym = pattern[SYM_W-1:0];
    assign last_sym  = pattern[(DEPTH-1)*SYM_W +: SYM_W];

    // Symbol expected at the current progress; don't-care once k reaches DEPTH.
    always_comb begin
        cur_sym = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (k_int == i) begin
                cur_sym = pattern[i*SYM_W +: SYM_W];
            end
        end
    end

    always_comb begin
        hold_case = 1'b0;
        k_adv     = '0;
        if (k_int > DEPTH) begin
            k_adv = '0;
        end else if (k_int < DEPTH && sym == cur_sym) begin
            k_adv = k_q + 1'b1;
        end else if (k_int == DEPTH && HOLD != 0 && sym == last_sym) begin
            hold_case = 1'b1;
            k_adv     = k_q;
        end else if (sym == first_sym) begin
            k_adv = KW'(1);
        end else begin
            k_adv = '0;
        end
    end

    assign hit = reset & in_valid & ~clear & (k_adv == KFull) & ~hold_case;

    always_comb begin
        k_d   = k_q;
        cnt_d = cnt_q;
        if (clear) begin
            k_d   = '0;
            cnt_d = '0;
        end else begin
            if (k_int > DEPTH) begin
                k_d = '0;
            end else if (in_valid) begin
                k_d = k_adv;
            end
            if (hit && cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k_q   <= '0;
            cnt_q <= '0;
        end else begin
            k_q   <= k_d;
            cnt_q <= cnt_d;
        end
    end

    assign progress  = k_q;
    assign detect    = (k_int == DEPTH);
    assign match_cnt = cnt_q;

endmodule
